bk_mp_add_sequencer: RTL and testbench
======================================

// Module: bk_mp_add_sequencer
// PURPOSE
//  Multi-precision add/subtract sequencer around one WIDTH-bit brent_kung_adder_full.
//  Operands stream in LSB-limb first over a valid/ready handshake; one limb is processed per cycle.
//  The inter-limb carry is held in a register, and each result limb is registered on the output.
//  Sits between operand source (bignum/crypto datapath) and result consumer; only user of its adder.
// PARAMETERS
//  WIDTH      32  limb width; power of two, >=4 (adder constraint)
//  MAX_LIMBS  8   max limbs per operation; limb counter is $clog2(MAX_LIMBS+1) bits
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      limb offered
//  in_ready   out  1      sequencer can accept limb
//  in_a       in   WIDTH  operand A limb
//  in_b       in   WIDTH  operand B limb
//  in_first   in   1      limb is LSB limb of new operation
//  in_last    in   1      limb is MSB limb of operation
//  in_sub     in   1      1=A-B, 0=A+B; sampled only on accepted first limb
//  out_valid  out  1      result limb held
//  out_ready  in   1      consumer takes result limb
//  out_sum    out  WIDTH  result limb
//  out_last   out  1      result limb is MSB limb
//  out_cout   out  1      on out_last: carry (add) / NOT borrow (sub); else 0
//  out_ovf    out  1      on out_last: signed overflow; else 0
//  proto_err  out  1      one-cycle pulse on protocol violation
//  busy       out  1      operation in progress (state BUSY)
// BEHAVIOUR
//  Reset: state=IDLE, carry_q=0, sub_q=0, limb_cnt=0, out_valid=0, out_sum=0, out_last=0,
//   out_cout=0, out_ovf=0, proto_err=0. Reset mid-operation discards the operation and any held limb.
//  in_ready = !out_valid || out_ready (single output stage, no bubble). Accept = in_valid && in_ready.
//  Output stage: loaded on accept; out_valid cleared when out_ready && !accept.
//  Output fields are stable while out_valid && !out_ready.
//  Latency 1 cycle accept->out_valid; throughput 1 limb/cycle under continuous out_ready.
//  Per accepted limb: start = (state==IDLE) || in_first; sub = start ? in_sub : sub_q;
//   b_eff = sub ? ~in_b : in_b; cin = start ? sub : carry_q.
//  Adder computes {cout,sum} = in_a + b_eff + cin.
//   out_sum <= sum; carry_q <= cout; sub_q <= sub.
//  ovf = (in_a[W-1]==b_eff[W-1]) && (sum[W-1]!=in_a[W-1]).
//  FSM IDLE -> BUSY: accept with !in_last. BUSY -> IDLE: accept with in_last, or forced last.
//   IDLE accept with in_last: single-limb op, stays IDLE.
//  limb_cnt: set to 1 on start, +1 on other accepts.
//   Forced last: accept with in_last=0 while cnt+1==MAX_LIMBS is treated as last.
//  Effective last sets out_last=1, out_cout=cout, out_ovf=ovf, carry_q<=0, and returns to IDLE.
//  proto_err pulses the cycle after:
//   (a) IDLE accept with in_first=0 (limb still processed as start);
//   (b) BUSY accept with in_first=1 (old op abandoned, new op started; no out_last is emitted for the old op);
//   (c) forced last.
//  Back-pressure: with in_ready=0, no state, carry or counter change.
//  Simultaneous out_ready and accept is required to sustain full rate.
//  in_* fields are ignored when no accept occurs.
// STRUCTURE
//  Package bk_seq_pkg: typedef enum logic {IDLE, BUSY} bk_seq_state_e; function limb_cnt_width(MAX_LIMBS).
//  One sub-module: brent_kung_adder_full #(WIDTH) u_add (A=in_a, B=b_eff, Cin=cin).
//  Purely combinational; no pipelining inside the adder.
//  Remaining logic (FSM, carry/sub regs, counter, output register) is inline in this module.
// TESTING
//  1) 2-limb add, WIDTH=32: A={0,FFFFFFFF}, B={0,00000001}.
//     -> out limbs 00000000, 00000001; last cout=0, ovf=0.
//  2) 1-limb sub 5-7 (first&last): -> out_sum=FFFFFFFE, out_cout=0 (borrow), ovf=0.
//     Then 7-5 -> 00000002, cout=1.
//  3) Signed overflow: 1-limb add 7FFFFFFF+00000001 -> out_sum=80000000, ovf=1, cout=0.
//  4) Back-pressure: hold out_ready=0 for 3 cycles during 4-limb add.
//     -> in_ready=0 while out_valid; outputs stable; same result as unstalled; no limb lost/duplicated.
//  5) Protocol: MAX_LIMBS=4, stream 5 limbs with in_last=0.
//     -> 4th limb out_last=1, proto_err pulse; 5th limb starts new op (proto_err again, case a).
//     First limb asserted mid-op -> proto_err, new carry chain.
//  6) Reset mid-op: assert rst_n=0 after limb 2 of 4.
//     -> out_valid=0, busy=0 immediately; next first limb computes with cin=in_sub.

Source files
------------

// File: rtl/bk_seq_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
// Holds the FSM state encoding and the limb-counter width function.
package bk_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bk_seq_state_e;

    function automatic int limb_cnt_width(input int max_limbs);
        return $clog2(max_limbs + 1);
    endfunction

endpackage

// File: rtl/brent_kung_adder_full.sv
// Combinational Brent-Kung parallel-prefix adder with carry in and carry out.
// WIDTH must be a power of two, at least 4.
module brent_kung_adder_full #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int L = $clog2(WIDTH);

    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign prop = A ^ B;

    always_comb begin
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = A & B;
        p = prop;
        // Fold the carry-in into bit 0 so every prefix G[i:0] is a carry.
        g[0] = g[0] | (p[0] & Cin);
        for (int d = 0; d < L; d++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 ** (d + 1))) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - 2 ** d]);
                    p[i] = p[i] & p[i - 2 ** d];
                end
            end
        end
        for (int d = L - 2; d >= 0; d--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (2 ** (d + 1))) == 2 ** d) &&
                    ((i + 1) > 2 ** (d + 1))) begin
                    g[i] = g[i] | (p[i] & g[i - 2 ** d]);
                    p[i] = p[i] & p[i - 2 ** d];
                end
            end
        end
        carry = {g, Cin};
    end

    assign Sum  = prop ^ carry[WIDTH-1:0];
    assign Cout = carry[WIDTH];

endmodule

// File: rtl/bk_mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one limb per cycle, LSB first,
// inter-limb carry held in a register, single registered output stage.
module bk_mp_add_sequencer
    import bk_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_LIMBS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             proto_err,
    output logic             busy
);

    localparam int CW = limb_cnt_width(MAX_LIMBS);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LIMBS);

    bk_seq_state_e    state_q, state_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             last_q, last_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             perr_q, perr_d;

    logic             accept, start, sub, cin, forced, eff_last, ovf;
    logic             add_cout;
    logic [WIDTH-1:0] b_eff, add_sum;
    logic [CW-1:0]    cnt_nxt;

    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign start    = (state_q == IDLE) || in_first;
    assign sub      = start ? in_sub : sub_q;
    assign b_eff    = sub ? ~in_b : in_b;
    assign cin      = start ? sub : carry_q;
    assign cnt_nxt  = start ? CW'(1) : cnt_q + CW'(1);
    assign forced   = !in_last && (cnt_nxt == MAX_CNT);
    assign eff_last = in_last || forced;
    assign ovf      = (in_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != in_a[WIDTH-1]);

    brent_kung_adder_full #(.WIDTH(WIDTH)) u_add (
        .A    (in_a),
        .B    (b_eff),
        .Cin  (cin),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        perr_d  = 1'b0;
        if (accept) begin
            state_d = eff_last ? IDLE : BUSY;
            carry_d = eff_last ? 1'b0 : add_cout;
            sub_d   = sub;
            cnt_d   = cnt_nxt;
            vld_d   = 1'b1;
            sum_d   = add_sum;
            last_d  = eff_last;
            cout_d  = eff_last && add_cout;
            ovf_d   = eff_last && ovf;
            perr_d  = ((state_q == IDLE) && !in_first) ||
                      ((state_q == BUSY) && in_first) ||
                      forced;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
        end
    end

    assign out_valid = vld_q;
    assign out_sum   = sum_q;
    assign out_last  = last_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign proto_err = perr_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_bk_mp_add_sequencer.sv
// Directed bench for bk_mp_add_sequencer (WIDTH=32, MAX_LIMBS=4).
module tb_bk_mp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic        in_first, in_last, in_sub;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic        out_last, out_cout, out_ovf, proto_err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bk_mp_add_sequencer #(.WIDTH(32), .MAX_LIMBS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .proto_err (proto_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic f, input logic l, input logic s);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = f;
        in_last  = l;
        in_sub   = s;
    endtask

    // Offer a limb and return #1 after the edge that accepted it.
    task automatic xfer(input logic [31:0] a, input logic [31:0] b,
                        input logic f, input logic l, input logic s);
        bit done = 0;
        drive(a, b, f, l, s);
        for (int i = 0; i < 20 && !done; i++) begin
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] s,
                           input logic l, input logic c, input logic o,
                           input logic pe);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, out_sum, s);
        check({tag, "_last"}, out_last, l);
        check({tag, "_cout"}, out_cout, c);
        check({tag, "_ovf"}, out_ovf, o);
        check({tag, "_perr"}, proto_err, pe);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_sub    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", out_sum, 0);
        check("rst_perr", proto_err, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(32'hFFFFFFFF, 32'h1, 1, 0, 0);
        chk_out("t1_l0", 32'h0, 0, 0, 0, 0);
        check("t1_busy", busy, 1);
        xfer(32'h0, 32'h0, 0, 1, 0);
        chk_out("t1_l1", 32'h1, 1, 0, 0, 0);
        check("t1_idle", busy, 0);
        @(posedge clk);
        #1;
        check("t1_drain", out_valid, 0);

        xfer(32'h5, 32'h7, 1, 1, 1);
        chk_out("t2_sub57", 32'hFFFFFFFE, 1, 0, 0, 0);
        xfer(32'h7, 32'h5, 1, 1, 1);
        chk_out("t2_sub75", 32'h2, 1, 1, 0, 0);

        xfer(32'h7FFFFFFF, 32'h1, 1, 1, 0);
        chk_out("t3_ovf", 32'h80000000, 1, 0, 1, 0);

        xfer(32'hFFFFFFFF, 32'h00000001, 1, 0, 0);
        chk_out("t4_l0", 32'h0, 0, 0, 0, 0);
        out_ready = 1'b0;
        drive(32'h80000000, 32'h80000000, 0, 0, 0);
        #1;
        check("t4_ready_lo", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t4_stall_rdy", in_ready, 0);
            check("t4_stall_vld", out_valid, 1);
            check("t4_stall_sum", out_sum, 0);
            check("t4_stall_last", out_last, 0);
            check("t4_stall_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_out("t4_l1", 32'h1, 0, 0, 0, 0);
        xfer(32'h00000000, 32'hFFFFFFFF, 0, 0, 0);
        chk_out("t4_l2", 32'h0, 0, 0, 0, 0);
        xfer(32'h7FFFFFFF, 32'h00000000, 0, 1, 0);
        chk_out("t4_l3", 32'h80000000, 1, 0, 1, 0);

        xfer(32'h1, 32'h1, 1, 0, 0);
        chk_out("t5_l0", 32'h2, 0, 0, 0, 0);
        xfer(32'h1, 32'h1, 0, 0, 0);
        chk_out("t5_l1", 32'h2, 0, 0, 0, 0);
        xfer(32'h1, 32'h1, 0, 0, 0);
        chk_out("t5_l2", 32'h2, 0, 0, 0, 0);
        xfer(32'h1, 32'h1, 0, 0, 0);
        chk_out("t5_forced", 32'h2, 1, 0, 0, 1);
        check("t5_forced_idle", busy, 0);
        xfer(32'hFFFFFFFF, 32'h1, 0, 0, 0);
        chk_out("t5_nofirst", 32'h0, 0, 0, 0, 1);
        check("t5_nofirst_busy", busy, 1);
        xfer(32'h5, 32'h3, 1, 0, 0);
        chk_out("t5_midfirst", 32'h8, 0, 0, 0, 1);
        xfer(32'h0, 32'h0, 0, 1, 0);
        chk_out("t5_end", 32'h0, 1, 0, 0, 0);

        xfer(32'hFFFFFFFF, 32'h1, 1, 0, 0);
        xfer(32'hFFFFFFFF, 32'h0, 0, 0, 0);
        chk_out("t6_l1", 32'h0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(32'h5, 32'h7, 1, 1, 1);
        chk_out("t6_after", 32'hFFFFFFFE, 1, 0, 0, 0);
        xfer(32'h3, 32'h4, 1, 1, 0);
        chk_out("t6_add", 32'h7, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
